// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter
//   Measures the high time and the rise-to-rise period of an asynchronous PWM
//   line, both in clkI cycles, and publishes one result per PWM period.
//   A line that stops toggling produces a timeout result instead. The timeout
//   result carries the stuck level and marks the measurement stale.
//
// Ports
//   clkI     in   1  system clock, rising edge
//   rstnI    in   1  asynchronous active-low reset
//   pwmI     in   1  PWM line, asynchronous to clkI
//   highO    out  W  high time of the last complete period
//   periodO  out  W  rise-to-rise period of the last complete period
//   validO   out  1  one-cycle strobe; highO/periodO/levelO updated this cycle
//   staleO   out  1  1 = no valid measurement since reset or last timeout
//   levelO   out  1  synchronised line level captured at the last timeout
module pwm_duty_meter #(
  parameter int unsigned W = 12
) (
  input  logic         clkI,
  input  logic         rstnI,
  input  logic         pwmI,
  output logic [W-1:0] highO,
  output logic [W-1:0] periodO,
  output logic         validO,
  output logic         staleO,
  output logic         levelO
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = W'(1);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  // Synchroniser (s1, s2) and edge-detect delay flop (s3)
  logic s1_q, s2_q, s3_q;

  state_e         state_q, state_d;
  logic [W-1:0]   hcnt_q, hcnt_d;
  logic [W-1:0]   pcnt_q, pcnt_d;
  logic [W-1:0]   high_q, high_d;
  logic [W-1:0]   period_q, period_d;
  logic           valid_q, valid_d;
  logic           stale_q, stale_d;
  logic           level_q, level_d;

  logic           rise_c;
  logic           fall_c;
  logic           pcnt_max_c;
  logic           timeout_c;

  assign rise_c     = s2_q & ~s3_q;
  assign fall_c     = ~s2_q & s3_q;
  assign pcnt_max_c = (pcnt_q == CNT_MAX);

  // Input synchroniser and edge-detect delay
  always_ff @(posedge clkI or negedge rstnI) begin
    if (!rstnI) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= pwmI;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // State, counters and registered results
  always_ff @(posedge clkI or negedge rstnI) begin
    if (!rstnI) begin
      state_q  <= ST_SYNC;
      hcnt_q   <= '0;
      pcnt_q   <= '0;
      high_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      stale_q  <= 1'b1;
      level_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      pcnt_q   <= pcnt_d;
      high_q   <= high_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      stale_q  <= stale_d;
      level_q  <= level_d;
    end
  end

  // Next-state and result logic. Edges are tested before the MAX compare so a
  // rise landing exactly on pcnt==MAX still yields a normal result.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    pcnt_d    = pcnt_q;
    high_d    = high_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    stale_d   = stale_q;
    level_d   = level_q;
    timeout_c = 1'b0;

    case (state_q)
      // First rise only arms the measurement
      ST_SYNC: begin
        if (rise_c) begin
          state_d = ST_HIGH;
          hcnt_d  = CNT_ONE;
          pcnt_d  = CNT_ONE;
        end else if (pcnt_max_c) begin
          timeout_c = 1'b1;
        end else begin
          pcnt_d = pcnt_q + CNT_ONE;
        end
      end

      ST_HIGH: begin
        if (fall_c) begin
          state_d = ST_LOW;
          // Saturate so a fall exactly at MAX cannot wrap the period counter
          if (!pcnt_max_c) begin
            pcnt_d = pcnt_q + CNT_ONE;
          end
        end else if (pcnt_max_c) begin
          timeout_c = 1'b1;
        end else begin
          hcnt_d = hcnt_q + CNT_ONE;
          pcnt_d = pcnt_q + CNT_ONE;
        end
      end

      // Rise closes the period and immediately opens the next one
      ST_LOW: begin
        if (rise_c) begin
          high_d   = hcnt_q;
          period_d = pcnt_q;
          valid_d  = 1'b1;
          stale_d  = 1'b0;
          hcnt_d   = CNT_ONE;
          pcnt_d   = CNT_ONE;
          state_d  = ST_HIGH;
        end else if (pcnt_max_c) begin
          timeout_c = 1'b1;
        end else begin
          pcnt_d = pcnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_SYNC;
        hcnt_d  = '0;
        pcnt_d  = '0;
      end
    endcase

    // Stuck line: report the level it is stuck at and re-arm from scratch
    if (timeout_c) begin
      valid_d  = 1'b1;
      period_d = CNT_MAX;
      high_d   = s2_q ? CNT_MAX : '0;
      level_d  = s2_q;
      stale_d  = 1'b1;
      state_d  = ST_SYNC;
      pcnt_d   = '0;
      hcnt_d   = '0;
    end
  end

  assign highO   = high_q;
  assign periodO = period_q;
  assign validO  = valid_q;
  assign staleO  = stale_q;
  assign levelO  = level_q;

endmodule
